// File: rtl/random_pkg.sv
// -----------------------------------------------------------------------------
// random_pkg
//   Shared constants and types for the random-word packing slice.
//   - WORD_WIDTH / DROP_W : default packer word width and dropped-counter width
//   - count_width()       : width of a 0..w fill counter
//   - fill_state_e        : packer status derived from the fill count
//   - debias_phase_e      : which half of a von Neumann pair is expected next
// No ports (package).
// -----------------------------------------------------------------------------
package random_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int DROP_W     = 8;

    // Bits needed to hold every value from 0 to w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic {
        ST_FILL,   // shift register still collecting bits
        ST_FULL    // shift register holds a complete word awaiting the buffer
    } fill_state_e;

    typedef enum logic {
        PH_FIRST,  // next valid bit opens a pair
        PH_SECOND  // next valid bit closes the pair
    } debias_phase_e;

endpackage

// File: rtl/vn_debias.sv
// -----------------------------------------------------------------------------
// vn_debias
//   Von Neumann debiaser. Valid input bits are taken in pairs; the first bit
//   of each pair is stored, and on the second bit's cycle the pair 10 emits 1
//   and 01 emits 0 (i.e. the stored first bit). Pairs 00 and 11 emit nothing.
//   Only instantiated by random_word_packer when RANDOM_PACKER_DEBIAS_EN is
//   defined.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   clear         in   synchronous flush back to the reset state
//   bit_in        in   raw serial bit
//   bit_valid     in   bit_in is valid this cycle
//   bit_out       out  debiased bit (meaningful only with bit_out_valid)
//   bit_out_valid out  a debiased bit is emitted this cycle (combinational)
// -----------------------------------------------------------------------------
module vn_debias
    import random_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_out,
    output logic bit_out_valid
);

    debias_phase_e phase, phase_next;
    logic          first_bit;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the processes are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_FIRST;
            first_bit <= 1'b0;
        end else if (clear) begin
            phase     <= PH_FIRST;
            first_bit <= 1'b0;
        end else begin
            phase <= phase_next;
            if (bit_valid && phase == PH_FIRST)
                first_bit <= bit_in;
        end
    end

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        phase_next    = phase;
        bit_out       = 1'b0;
        bit_out_valid = 1'b0;
        if (bit_valid) begin
            case (phase)
                PH_FIRST: begin
                    phase_next = PH_SECOND;
                end
                PH_SECOND: begin
                    phase_next    = PH_FIRST;
                    // Unequal pair: the first bit is the emitted value.
                    bit_out_valid = (first_bit != bit_in);
                    bit_out       = first_bit;
                end
                default: phase_next = PH_FIRST;
            endcase
        end
    end

endmodule

// File: rtl/random_word_packer.sv
// -----------------------------------------------------------------------------
// random_word_packer
//   Packs a serial pseudo-random bit stream (one bit per strobe) into WIDTH-bit
//   words, first accepted bit in the MSB, and presents them on a valid/ready
//   interface. The in-flight shift register plus a one-word output buffer give
//   one word of slack; bits arriving when both are full are dropped and counted
//   in a saturating counter.
//
//   Optional feature macro: RANDOM_PACKER_DEBIAS_EN
//     defined   : a vn_debias stage filters the input stream before packing;
//                 drops are counted per emitted (debiased) bit.
//     undefined : every valid input bit feeds the packer directly.
//
// Parameters:
//   WIDTH   output word width in bits (>= 2)
//   DROP_W  width of the saturating dropped-bit counter
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous flush, same effect as reset
//   bit_in      in   serial random bit
//   bit_valid   in   bit_in is valid this cycle
//   word_out    out  packed word (stable while word_valid && !word_ready)
//   word_valid  out  word_out holds an unconsumed word
//   word_ready  in   consumer accepts word_out this cycle
//   dropped     out  saturating count of discarded input bits
// -----------------------------------------------------------------------------
module random_word_packer
    import random_pkg::*;
#(
    parameter int WIDTH  = WORD_WIDTH,
    parameter int DROP_W = random_pkg::DROP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WIDTH-1:0]  word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [DROP_W-1:0] dropped
);

    localparam int               CNT_W    = count_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit stream actually offered to the packer.
    logic in_bit;
    logic in_valid;

`ifdef RANDOM_PACKER_DEBIAS_EN
    vn_debias u_debias (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .bit_out       (in_bit),
        .bit_out_valid (in_valid)
    );
`else
    assign in_bit   = bit_in;
    assign in_valid = bit_valid;
`endif

    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] count;

    fill_state_e fill_state;
    logic        load;     // move the completed word into the output buffer
    logic        accept;   // the offered bit enters the shift register
    logic        drop;     // the offered bit is discarded

    always_comb begin
        fill_state = (count == CNT_FULL) ? ST_FULL : ST_FILL;
        // A complete word moves out when the buffer is empty or draining now.
        load       = (fill_state == ST_FULL) && (!word_valid || word_ready);
        // A load frees the shift register this same edge, so the new bit
        // becomes bit 0 of the next word instead of being dropped.
        accept     = in_valid && ((fill_state == ST_FILL) || load);
        drop       = in_valid && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            count      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            dropped    <= '0;
        end else if (clear) begin
            shift_reg  <= '0;
            count      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            dropped    <= '0;
        end else begin
            // Output buffer: a load overrides a same-edge handshake, so a
            // consumed word is replaced with no bubble.
            if (load) begin
                word_out   <= shift_reg;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // Stale bits left in shift_reg after a load are harmless: a word
            // is only emitted after WIDTH fresh shifts have pushed them out.
            if (accept)
                shift_reg <= {shift_reg[WIDTH-2:0], in_bit};

            if (load)
                count <= accept ? CNT_ONE : '0;
            else if (accept)
                count <= count + CNT_ONE;

            if (drop && (dropped != '1))
                dropped <= dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_random_word_packer.sv
// -----------------------------------------------------------------------------
// tb_random_word_packer
//   Scoreboard bench for random_word_packer. The stimulus process keeps a
//   bit-queue reference model of the packer (and of the debiaser when
//   RANDOM_PACKER_DEBIAS_EN is defined) and pushes every word the model places
//   in the output buffer onto exp_q. A negedge monitor compares word_valid with
//   the model's buffer state and word_out with the head of exp_q, popping on
//   each handshake.
// -----------------------------------------------------------------------------
module tb_random_word_packer;

    localparam int W        = 16;
    localparam int DW       = 8;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          word_ready = 1'b0;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic [DW-1:0] dropped;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit           m_partial[$];   // bits collected toward the next word
    logic [W-1:0] exp_q[$];       // words the model has placed in the buffer
    bit           m_buf_full;
    int           m_drop;
    bit           m_have_first;
    bit           m_first;

    // Monitor bookkeeping.
    int           cycle      = 0;
    bit           spacing_en = 1'b0;
    int           last_hs    = -1;
    int           hs_count   = 0;
    logic [W-1:0] last_word  = '0;

    random_word_packer #(.WIDTH(W), .DROP_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic model_reset();
        m_partial.delete();
        exp_q.delete();
        m_buf_full   = 1'b0;
        m_drop       = 0;
        m_have_first = 1'b0;
        m_first      = 1'b0;
    endtask

    // One clock edge of the reference model, given the inputs held across it.
    task automatic model_edge(input bit b, input bit v, input bit rdy);
        bit           eb;
        bit           ev;
        logic [W-1:0] word;
        eb = b;
        ev = v;
`ifdef RANDOM_PACKER_DEBIAS_EN
        ev = 1'b0;
        if (v) begin
            if (!m_have_first) begin
                m_first      = b;
                m_have_first = 1'b1;
            end else begin
                m_have_first = 1'b0;
                if (m_first != b) begin
                    ev = 1'b1;
                    eb = m_first;
                end
            end
        end
`endif
        if (m_buf_full && rdy)
            m_buf_full = 1'b0;
        if (m_partial.size() == W && !m_buf_full) begin
            word = '0;
            foreach (m_partial[i])
                word = {word[W-2:0], m_partial[i]};
            exp_q.push_back(word);
            m_buf_full = 1'b1;
            m_partial.delete();
        end
        if (ev) begin
            if (m_partial.size() < W)
                m_partial.push_back(eb);
            else if (m_drop < DROP_MAX)
                m_drop++;
        end
    endtask

    // Drive inputs for one cycle, advance the model at the edge, settle.
    task automatic step(input bit b, input bit v, input bit rdy, input bit clr);
        bit_in     = b;
        bit_valid  = v;
        word_ready = rdy;
        clear      = clr;
        @(posedge clk);
        if (clr)
            model_reset();
        else
            model_edge(b, v, rdy);
        #1;
        clear     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [W-1:0] w, input bit rdy);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], 1'b1, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("word_valid", {31'd0, word_valid}, {31'd0, m_buf_full});
            if (word_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word_out: got 0x%0h with no expected word at cycle %0d",
                             word_out, cycle);
                end else begin
                    check("word_out", {16'd0, word_out}, {16'd0, exp_q[0]});
                    if (word_ready && !clear) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        last_word = word_out;
                        if (spacing_en && last_hs >= 0)
                            check("word_spacing", cycle - last_hs, 16);
                        last_hs = cycle;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] lfsr;
        logic         fb;
        int           hs_mark;
        bit           pairs[8];

        model_reset();
        #6;
        check("reset_word_out", {16'd0, word_out}, 32'd0);
        check("reset_word_valid", {31'd0, word_valid}, 32'd0);
        check("reset_dropped", {24'd0, dropped}, 32'd0);
        #6 rst_n = 1'b1;

        // Basic pack: first accepted bit lands in the MSB.
        feed_word(16'hACE1, 1'b1);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("basic_valid_latency", {31'd0, word_valid}, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("basic_valid_next", {31'd0, word_valid}, 32'd1);
        check("basic_word", {16'd0, word_out}, 32'h0000ACE1);
`endif
        idle(4, 1'b1);
        check("basic_dropped", {24'd0, dropped}, m_drop);

        // Backpressure: 40 bits with the consumer stalled.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check("bp_dropped_model", {24'd0, dropped}, m_drop);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("bp_dropped", {24'd0, dropped}, 32'd8);
`endif
        hs_mark = hs_count;
        idle(40, 1'b1);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("bp_words_out", hs_count - hs_mark, 2);
`endif
        check("bp_drained", exp_q.size(), 0);

        // Zero-bubble stream of lfsr output with the consumer always ready.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        lfsr = 16'hACE1;
        hs_mark = hs_count;
`ifndef RANDOM_PACKER_DEBIAS_EN
        spacing_en = 1'b1;
        last_hs    = -1;
`endif
        for (int i = 0; i < 160; i++) begin
            step(lfsr[0], 1'b1, 1'b1, 1'b0);
            fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
            lfsr = {fb, lfsr[W-1:1]};
        end
        idle(20, 1'b1);
        spacing_en = 1'b0;
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("stream_words", hs_count - hs_mark, 10);
`endif
        check("stream_dropped", {24'd0, dropped}, m_drop);

        // Saturation of the dropped counter, then clear.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check("sat_dropped_model", {24'd0, dropped}, m_drop);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("sat_dropped", {24'd0, dropped}, DROP_MAX);
`endif
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_hold", {24'd0, dropped}, m_drop);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_dropped", {24'd0, dropped}, 32'd0);
        check("clear_word_valid", {31'd0, word_valid}, 32'd0);

        // Asynchronous reset in the middle of a word.
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_word_out", {16'd0, word_out}, 32'd0);
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_dropped", {24'd0, dropped}, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        feed_word(16'hF973, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
`ifndef RANDOM_PACKER_DEBIAS_EN
        check("rst_next_word", {16'd0, word_out}, 32'h0000F973);
`endif
        idle(4, 1'b1);

        // Pair pattern 01,10,11,00 repeated eight times.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pairs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        hs_mark = hs_count;
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++)
                step(pairs[i], 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
`ifdef RANDOM_PACKER_DEBIAS_EN
        check("pairs_words", hs_count - hs_mark, 1);
        check("pairs_last_word", {16'd0, last_word}, 32'h00005555);
`else
        check("pairs_words", hs_count - hs_mark, 4);
        check("pairs_last_word", {16'd0, last_word}, 32'h00006C6C);
`endif

        // Randomized traffic: sparse bits, random backpressure, rare clears.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        check("random_dropped", {24'd0, dropped}, m_drop);
        idle(40, 1'b1);
        check("random_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
